// File: rtl/fpc_sequencer.sv
// Floating-point coprocessor sequencer: decodes COP1 instructions, latches operands and
// times execution latency. Define FPC_SEQ_PERF_CNT_EN to enable the stall_cycles counter.
module fpc_sequencer #(
    parameter int ADD_LAT = 3,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        inst_valid,
    input  logic [31:0] data_in,
    output logic        inst_ready,
    output logic [2:0]  fpu_op,
    output logic [4:0]  fs_q,
    output logic [4:0]  ft_q,
    output logic [4:0]  fd_q,
    output logic [2:0]  cc_q,
    output logic        from_processor,
    output logic [31:0] data_q,
    output logic        reg_wr_en,
    output logic        cc_wr_en,
    output logic        illegal,
    output logic [31:0] stall_cycles
);

    // Handshake: an instruction transfers on a rising edge where inst_valid && inst_ready;
    // inst_ready depends only on state, and inst/data_in are ignored whenever it is low.

    localparam logic [4:0] ADD_CNT = 5'(ADD_LAT - 1);
    localparam logic [4:0] MUL_CNT = 5'(MUL_LAT - 1);
    localparam logic [4:0] DIV_CNT = 5'(DIV_LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  cnt;
    logic        is_cmp;
    logic        accept;
    logic        done;

    logic        dec_legal;
    logic        dec_illegal;
    logic [2:0]  dec_op;
    logic [4:0]  dec_cnt;
    logic        dec_from;
    logic        dec_cmp;

    assign accept = inst_valid && inst_ready;
    assign done   = (state == EXEC) && (cnt == 5'd0);

    always_comb begin
        dec_legal   = 1'b0;
        dec_illegal = 1'b0;
        dec_op      = 3'd0;
        dec_cnt     = 5'd0;
        dec_from    = 1'b0;
        dec_cmp     = 1'b0;
        if (inst[31:26] == 6'h11) begin
            case (inst[25:21])
                5'h00: ;  // mfc1 is handled entirely by the processor side
                5'h04: begin
                    dec_legal = 1'b1;
                    dec_from  = 1'b1;
                end
                5'h10: begin
                    dec_legal = 1'b1;
                    case (inst[5:0])
                        6'h00: begin dec_op = 3'd0; dec_cnt = ADD_CNT; end
                        6'h01: begin dec_op = 3'd1; dec_cnt = ADD_CNT; end
                        6'h02: begin dec_op = 3'd2; dec_cnt = MUL_CNT; end
                        6'h03: begin dec_op = 3'd3; dec_cnt = DIV_CNT; end
                        6'h06: dec_op = 3'd4;
                        6'h32: begin dec_op = 3'd5; dec_cmp = 1'b1; end
                        6'h3C: begin dec_op = 3'd6; dec_cmp = 1'b1; end
                        6'h3E: begin dec_op = 3'd7; dec_cmp = 1'b1; end
                        default: begin
                            dec_legal   = 1'b0;
                            dec_illegal = 1'b1;
                        end
                    endcase
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && dec_legal) state_next = EXEC;
            EXEC:    if (cnt == 5'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 5'd0;
            is_cmp         <= 1'b0;
            fpu_op         <= 3'd0;
            fs_q           <= 5'd0;
            ft_q           <= 5'd0;
            fd_q           <= 5'd0;
            cc_q           <= 3'd0;
            from_processor <= 1'b0;
            data_q         <= 32'd0;
            illegal        <= 1'b0;
        end else begin
            state   <= state_next;
            illegal <= accept && dec_illegal;
            if (state == IDLE && accept && dec_legal) begin
                cnt            <= dec_cnt;
                is_cmp         <= dec_cmp;
                fpu_op         <= dec_op;
                ft_q           <= inst[20:16];
                fs_q           <= inst[15:11];
                fd_q           <= inst[10:6];
                cc_q           <= inst[10:8];
                from_processor <= dec_from;
                data_q         <= dec_from ? data_in : 32'd0;
            end else if (state == EXEC && cnt != 5'd0) begin
                cnt <= cnt - 5'd1;
            end
        end
    end

    assign inst_ready = (state == IDLE);
    assign reg_wr_en  = done && !is_cmp;
    assign cc_wr_en   = done && is_cmp;

`ifdef FPC_SEQ_PERF_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'd0;
        end else if (inst_valid && !inst_ready && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_fpc_sequencer.sv
// Directed bench for fpc_sequencer: a vector table of single instructions plus
// hand-written sequences for queued issue and reset during execution.
module tb_fpc_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] data_in;
    logic        inst_ready;
    logic [2:0]  fpu_op;
    logic [4:0]  fs_q;
    logic [4:0]  ft_q;
    logic [4:0]  fd_q;
    logic [2:0]  cc_q;
    logic        from_processor;
    logic [31:0] data_q;
    logic        reg_wr_en;
    logic        cc_wr_en;
    logic        illegal;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    fpc_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .data_in        (data_in),
        .inst_ready     (inst_ready),
        .fpu_op         (fpu_op),
        .fs_q           (fs_q),
        .ft_q           (ft_q),
        .fd_q           (fd_q),
        .cc_q           (cc_q),
        .from_processor (from_processor),
        .data_q         (data_q),
        .reg_wr_en      (reg_wr_en),
        .cc_wr_en       (cc_wr_en),
        .illegal        (illegal),
        .stall_cycles   (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] data;
        int          lat;
        logic [2:0]  op;
        logic        chk_op;
        logic        reg_w;
        logic        cc_w;
        logic        ill;
        logic        from;
        logic [4:0]  fs;
        logic [4:0]  ft;
        logic [4:0]  fd;
        logic [2:0]  cc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [5:0] opc, input logic [4:0] fpop,
                                input logic [4:0] ft, input logic [4:0] fs, input logic [4:0] fd,
                                input logic [5:0] fn, input logic [31:0] d, input int lat,
                                input logic [2:0] op, input logic chk_op, input logic reg_w,
                                input logic cc_w, input logic ill, input logic from,
                                input logic [2:0] cc);
        vec_t v;
        v.name = nm;   v.inst = {opc, fpop, ft, fs, fd, fn}; v.data = d;
        v.lat = lat;   v.op = op;       v.chk_op = chk_op;
        v.reg_w = reg_w; v.cc_w = cc_w; v.ill = ill; v.from = from;
        v.fs = fs;     v.ft = ft;       v.fd = fd;   v.cc = cc;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; inst_valid = 1'b0; inst = 32'd0; data_in = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        int last;
        logic exp_ready;
        last = (v.lat > 0) ? v.lat + 1 : 2;
        @(negedge clk);
        inst = v.inst; data_in = v.data; inst_valid = 1'b1;
        check({v.name, " ready_c0"}, 32'(inst_ready), 32'd1);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            inst_valid = 1'b0;
            inst = $urandom;
            data_in = $urandom;
            exp_ready = (v.lat == 0) || (c > v.lat);
            check($sformatf("%s ready_c%0d", v.name, c), 32'(inst_ready), 32'(exp_ready));
            check($sformatf("%s reg_wr_c%0d", v.name, c), 32'(reg_wr_en), 32'(v.reg_w && c == v.lat));
            check($sformatf("%s cc_wr_c%0d", v.name, c), 32'(cc_wr_en), 32'(v.cc_w && c == v.lat));
            check($sformatf("%s illegal_c%0d", v.name, c), 32'(illegal), 32'(v.ill && c == 1));
            if (c <= v.lat) begin
                check($sformatf("%s fs_q_c%0d", v.name, c), 32'(fs_q), 32'(v.fs));
                check($sformatf("%s ft_q_c%0d", v.name, c), 32'(ft_q), 32'(v.ft));
                check($sformatf("%s fd_q_c%0d", v.name, c), 32'(fd_q), 32'(v.fd));
                check($sformatf("%s cc_q_c%0d", v.name, c), 32'(cc_q), 32'(v.cc));
                check($sformatf("%s from_c%0d", v.name, c), 32'(from_processor), 32'(v.from));
                if (v.chk_op)
                    check($sformatf("%s fpu_op_c%0d", v.name, c), 32'(fpu_op), 32'(v.op));
                if (v.from)
                    check($sformatf("%s data_q_c%0d", v.name, c), data_q, v.data);
            end
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " ready"}, 32'(inst_ready), 32'd1);
        check({nm, " fpu_op"}, 32'(fpu_op), 32'd0);
        check({nm, " fs_q"}, 32'(fs_q), 32'd0);
        check({nm, " ft_q"}, 32'(ft_q), 32'd0);
        check({nm, " fd_q"}, 32'(fd_q), 32'd0);
        check({nm, " cc_q"}, 32'(cc_q), 32'd0);
        check({nm, " from"}, 32'(from_processor), 32'd0);
        check({nm, " data_q"}, data_q, 32'd0);
        check({nm, " reg_wr"}, 32'(reg_wr_en), 32'd0);
        check({nm, " cc_wr"}, 32'(cc_wr_en), 32'd0);
        check({nm, " illegal"}, 32'(illegal), 32'd0);
        check({nm, " stall"}, stall_cycles, 32'd0);
    endtask

    initial begin
        logic        accepted;
        logic [31:0] exp_stall;
        rst = 1'b1; inst_valid = 1'b0; inst = 32'd0; data_in = 32'd0;

        //          name       opc    fpop   ft     fs     fd     funct  data          lat op  chk reg cc ill frm cc
        vecs[0]  = mk("add",   6'h11, 5'h10, 5'd2,  5'd1,  5'd3,  6'h00, 32'h0,        3, 3'd0, 1, 1, 0, 0, 0, 3'd0);
        vecs[1]  = mk("sub",   6'h11, 5'h10, 5'd9,  5'd4,  5'd7,  6'h01, 32'h0,        3, 3'd1, 1, 1, 0, 0, 0, 3'd1);
        vecs[2]  = mk("mul",   6'h11, 5'h10, 5'd12, 5'd11, 5'd10, 6'h02, 32'h0,        4, 3'd2, 1, 1, 0, 0, 0, 3'd2);
        vecs[3]  = mk("mov",   6'h11, 5'h10, 5'd0,  5'd30, 5'd31, 6'h06, 32'h0,        1, 3'd4, 1, 1, 0, 0, 0, 3'd7);
        vecs[4]  = mk("mtc1",  6'h11, 5'h04, 5'd8,  5'd5,  5'd0,  6'h00, 32'hDEADBEEF, 1, 3'd0, 0, 1, 0, 0, 1, 3'd0);
        vecs[5]  = mk("c_lt",  6'h11, 5'h10, 5'd6,  5'd2,  5'd8,  6'h3C, 32'h0,        1, 3'd6, 1, 0, 1, 0, 0, 3'd2);
        vecs[6]  = mk("c_eq",  6'h11, 5'h10, 5'd3,  5'd4,  5'd20, 6'h32, 32'h0,        1, 3'd5, 1, 0, 1, 0, 0, 3'd5);
        vecs[7]  = mk("c_le",  6'h11, 5'h10, 5'd17, 5'd18, 5'd28, 6'h3E, 32'h0,        1, 3'd7, 1, 0, 1, 0, 0, 3'd7);
        vecs[8]  = mk("ill_fn",6'h11, 5'h10, 5'd1,  5'd2,  5'd3,  6'h3F, 32'h0,        0, 3'd0, 0, 0, 0, 1, 0, 3'd0);
        vecs[9]  = mk("ill_fp",6'h11, 5'h08, 5'd1,  5'd2,  5'd3,  6'h00, 32'h0,        0, 3'd0, 0, 0, 0, 1, 0, 3'd0);
        vecs[10] = mk("mfc1",  6'h11, 5'h00, 5'd1,  5'd2,  5'd3,  6'h00, 32'h1234,     0, 3'd0, 0, 0, 0, 0, 0, 3'd0);
        vecs[11] = mk("lw",    6'h23, 5'h10, 5'd1,  5'd2,  5'd3,  6'h02, 32'h0,        0, 3'd0, 0, 0, 0, 0, 0, 3'd0);

        do_reset();
        @(negedge clk);
        check_all_zero("reset");

        for (int i = 0; i < 12; i++) apply_vec(vecs[i]);

        // div held valid with an add queued behind it
`ifdef FPC_SEQ_PERF_CNT_EN
        exp_stall = 32'd12;
`else
        exp_stall = 32'd0;
`endif
        do_reset();
        @(negedge clk);
        inst = {6'h11, 5'h10, 5'd2, 5'd1, 5'd4, 6'h03}; inst_valid = 1'b1;
        check("div ready_c0", 32'(inst_ready), 32'd1);
        accepted = 1'b0;
        for (int c = 1; c <= 20 && !accepted; c++) begin
            @(negedge clk);
            inst = {6'h11, 5'h10, 5'd7, 5'd5, 5'd6, 6'h00};
            check($sformatf("div ready_c%0d", c), 32'(inst_ready), 32'(c == 13));
            check($sformatf("div reg_wr_c%0d", c), 32'(reg_wr_en), 32'(c == 12));
            if (c <= 12) check($sformatf("div fpu_op_c%0d", c), 32'(fpu_op), 32'd3);
            if (inst_ready) begin
                accepted = 1'b1;
                check("div stall", stall_cycles, exp_stall);
            end
        end
        if (!accepted) check("div accept_timeout", 32'd0, 32'd1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            inst_valid = 1'b0;
            check($sformatf("queued_add reg_wr_c%0d", c), 32'(reg_wr_en), 32'(c == 3));
            check($sformatf("queued_add fd_q_c%0d", c), 32'(fd_q), 32'd6);
            check($sformatf("queued_add fpu_op_c%0d", c), 32'(fpu_op), 32'd0);
        end
        @(negedge clk);
        check("queued_add ready", 32'(inst_ready), 32'd1);

        // reset during cycle 2 of a mul aborts it
        do_reset();
        @(negedge clk);
        inst = {6'h11, 5'h10, 5'd3, 5'd2, 5'd9, 6'h02}; data_in = 32'h5555AAAA; inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        check("mulrst ready_c1", 32'(inst_ready), 32'd0);
        check("mulrst fd_q_c1", 32'(fd_q), 32'd9);
        check("mulrst reg_wr_c1", 32'(reg_wr_en), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        check("mulrst reg_wr_c2", 32'(reg_wr_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("mulrst c3");
        for (int c = 4; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("mulrst reg_wr_c%0d", c), 32'(reg_wr_en), 32'd0);
            check($sformatf("mulrst ready_c%0d", c), 32'(inst_ready), 32'd1);
        end

        // reset wins over a valid instruction presented in the same cycle
        @(negedge clk);
        rst = 1'b1; inst_valid = 1'b1; inst = {6'h11, 5'h10, 5'd1, 5'd1, 5'd1, 6'h00};
        @(negedge clk);
        rst = 1'b0; inst_valid = 1'b0;
        check_all_zero("rst_over_valid");
        @(negedge clk);
        check("rst_over_valid ready_next", 32'(inst_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
